// File: rtl/gate_sweep_ctrl.sv
// Sweeps a small combinational gate through every input vector, compares its output to a
// captured truth table and reports mismatches. Optional build macro: SWEEP_STOP_ON_FAIL_EN.
module gate_sweep_ctrl #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [(1<<N_IN)-1:0]  exp_tt_i,
    output logic [N_IN-1:0]       dut_in_o,
    input  logic                  dut_out_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [N_IN:0]         err_cnt_o,
    output logic [N_IN-1:0]       fail_vec_o,
    output logic                  fail_vld_o
);

    localparam int              NV        = 1 << N_IN;
    localparam logic [N_IN:0]   LAST_VEC  = (N_IN+1)'(NV - 1);
    localparam logic [N_IN:0]   ERR_MAX   = (N_IN+1)'(NV);
    localparam logic [3:0]      SETTLE_LD = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [N_IN:0]       vec_q, vec_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [NV-1:0]       exp_q, exp_d;
    logic [N_IN:0]       err_cnt_q, err_cnt_d;
    logic [N_IN-1:0]     fail_vec_q, fail_vec_d;
    logic                fail_vld_q, fail_vld_d;
    logic                pass_q, pass_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic [N_IN-1:0]     dut_in_q, dut_in_d;

    logic                accept_s;
    logic                mismatch_s;
    logic                last_s;
    logic                stop_s;
    logic [N_IN:0]       vec_next_s;

    // Sweep decode: start acceptance, compare result and exit conditions.
    always_comb begin
        // The DONE cycle's exit edge is the earliest point a new sweep may begin.
        accept_s   = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));
        mismatch_s = dut_out_i ^ exp_q[vec_q[N_IN-1:0]];
        last_s     = (vec_q == LAST_VEC);
        vec_next_s = vec_q + (N_IN+1)'(1);
`ifdef SWEEP_STOP_ON_FAIL_EN
        stop_s     = (err_cnt_q != (N_IN+1)'(0));
`else
        stop_s     = 1'b0;
`endif
    end

    // Next-state and result-register logic.
    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        cnt_d      = cnt_q;
        exp_d      = exp_q;
        err_cnt_d  = err_cnt_q;
        fail_vec_d = fail_vec_q;
        fail_vld_d = fail_vld_q;
        pass_d     = pass_q;
        done_d     = 1'b0;
        busy_d     = busy_q;
        dut_in_d   = dut_in_q;

        if (accept_s) begin
            state_d    = S_DRIVE;
            exp_d      = exp_tt_i;
            err_cnt_d  = (N_IN+1)'(0);
            fail_vec_d = N_IN'(0);
            fail_vld_d = 1'b0;
            pass_d     = 1'b0;
            vec_d      = (N_IN+1)'(0);
            cnt_d      = SETTLE_LD;
            busy_d     = 1'b1;
            dut_in_d   = N_IN'(0);
        end else begin
            case (state_q)
                S_IDLE: begin
                    busy_d   = 1'b0;
                    dut_in_d = N_IN'(0);
                end
                S_DRIVE: begin
                    // The compare happens on the last settle cycle, as DRIVE hands over to SAMPLE.
                    if (cnt_q == 4'd0) begin
                        state_d = S_SAMPLE;
                        if (mismatch_s) begin
                            if (err_cnt_q != ERR_MAX) begin
                                err_cnt_d = err_cnt_q + (N_IN+1)'(1);
                            end else begin
                                err_cnt_d = err_cnt_q;
                            end
                            if (!fail_vld_q) begin
                                fail_vec_d = vec_q[N_IN-1:0];
                                fail_vld_d = 1'b1;
                            end else begin
                                fail_vec_d = fail_vec_q;
                            end
                        end else begin
                            err_cnt_d = err_cnt_q;
                        end
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                S_SAMPLE: begin
                    if (last_s || stop_s) begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        busy_d   = 1'b0;
                        pass_d   = (err_cnt_q == (N_IN+1)'(0));
                        dut_in_d = N_IN'(0);
                    end else begin
                        state_d  = S_DRIVE;
                        vec_d    = vec_next_s;
                        cnt_d    = SETTLE_LD;
                        dut_in_d = vec_next_s[N_IN-1:0];
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d  = S_IDLE;
                    busy_d   = 1'b0;
                    dut_in_d = N_IN'(0);
                end
            endcase
        end
    end

    // State and output registers; reset aborts any sweep without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            vec_q      <= (N_IN+1)'(0);
            cnt_q      <= 4'd0;
            exp_q      <= NV'(0);
            err_cnt_q  <= (N_IN+1)'(0);
            fail_vec_q <= N_IN'(0);
            fail_vld_q <= 1'b0;
            pass_q     <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            dut_in_q   <= N_IN'(0);
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            cnt_q      <= cnt_d;
            exp_q      <= exp_d;
            err_cnt_q  <= err_cnt_d;
            fail_vec_q <= fail_vec_d;
            fail_vld_q <= fail_vld_d;
            pass_q     <= pass_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            dut_in_q   <= dut_in_d;
        end
    end

    assign dut_in_o   = dut_in_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign pass_o     = pass_q;
    assign err_cnt_o  = err_cnt_q;
    assign fail_vec_o = fail_vec_q;
    assign fail_vld_o = fail_vld_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Randomized self-checking bench for gate_sweep_ctrl: a 2-input/SETTLE=1 instance and a
// 3-input/SETTLE=3 instance driving truth-table gates, checked against a sweep-level model.
module tb_gate_sweep_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: N_IN=2, SETTLE=1
    logic       start_a = 1'b0;
    logic [3:0] exp_a = 4'd0;
    logic [1:0] din_a;
    logic       dout_a, busy_a, done_a, pass_a, fvld_a;
    logic [2:0] err_a;
    logic [1:0] fv_a;
    // Instance B: N_IN=3, SETTLE=3
    logic       start_b = 1'b0;
    logic [7:0] exp_b = 8'd0;
    logic [2:0] din_b;
    logic       dout_b, busy_b, done_b, pass_b, fvld_b;
    logic [3:0] err_b;
    logic [2:0] fv_b;

    gate_sweep_ctrl #(.N_IN(2), .SETTLE(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start_i(start_a), .exp_tt_i(exp_a),
        .dut_in_o(din_a), .dut_out_i(dout_a), .busy_o(busy_a), .done_o(done_a),
        .pass_o(pass_a), .err_cnt_o(err_a), .fail_vec_o(fv_a), .fail_vld_o(fvld_a));

    gate_sweep_ctrl #(.N_IN(3), .SETTLE(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start_i(start_b), .exp_tt_i(exp_b),
        .dut_in_o(din_b), .dut_out_i(dout_b), .busy_o(busy_b), .done_o(done_b),
        .pass_o(pass_b), .err_cnt_o(err_b), .fail_vec_o(fv_b), .fail_vld_o(fvld_b));

    // Gates under test: truth tables, optionally behind a two-register settling delay.
    logic [3:0] gtt_a = 4'b1000;
    logic [7:0] gtt_b = 8'h80;
    logic       slow_a = 1'b0;
    logic       p1_a = 1'b0, p2_a = 1'b0, p1_b = 1'b0, p2_b = 1'b0;
    always @(posedge clk) begin
        p1_a <= gtt_a[din_a];
        p2_a <= p1_a;
        p1_b <= gtt_b[din_b];
        p2_b <= p1_b;
    end
    assign dout_a = slow_a ? p2_a : gtt_a[din_a];
    assign dout_b = p2_b;

    // Selected-instance view used by the sweep task.
    logic       sel = 1'b0;
    logic       busy_m, done_m, pass_m, fvld_m;
    logic [3:0] err_m;
    logic [2:0] din_m, fv_m;
    always_comb begin
        busy_m = sel ? busy_b : busy_a;
        done_m = sel ? done_b : done_a;
        pass_m = sel ? pass_b : pass_a;
        fvld_m = sel ? fvld_b : fvld_a;
        err_m  = sel ? err_b  : {1'b0, err_a};
        din_m  = sel ? din_b  : {1'b0, din_a};
        fv_m   = sel ? fv_b   : {1'b0, fv_a};
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, expv, $time);
        end
    endtask

    // Sweep-level reference: which vectors mismatch, first failure, where the sweep ends.
    // A stale gate presents the previous vector's result (vector 0 sees the idle input 0).
    function automatic void model(input logic [7:0] ett, input logic [7:0] g, input int nv,
                                  input bit stale, output int ecnt, output int fvec,
                                  output bit fvld, output int last);
        int idx;
        ecnt = 0; fvec = 0; fvld = 1'b0; last = nv - 1;
        for (int v = 0; v < nv; v++) begin
            idx = stale ? ((v == 0) ? 0 : v - 1) : v;
            if (g[idx] != ett[v]) begin
                if (!fvld) begin
                    fvld = 1'b1;
                    fvec = v;
                end
                ecnt++;
`ifdef SWEEP_STOP_ON_FAIL_EN
                last = v;
                break;
`endif
            end
        end
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, ".a_din"},  32'(din_a),  32'd0);
        check({tag, ".a_busy"}, 32'(busy_a), 32'd0);
        check({tag, ".a_done"}, 32'(done_a), 32'd0);
        check({tag, ".a_pass"}, 32'(pass_a), 32'd0);
        check({tag, ".a_err"},  32'(err_a),  32'd0);
        check({tag, ".a_fv"},   32'(fv_a),   32'd0);
        check({tag, ".a_fvld"}, 32'(fvld_a), 32'd0);
        check({tag, ".b_din"},  32'(din_b),  32'd0);
        check({tag, ".b_busy"}, 32'(busy_b), 32'd0);
        check({tag, ".b_err"},  32'(err_b),  32'd0);
        check({tag, ".b_fvld"}, 32'(fvld_b), 32'd0);
    endtask

    task automatic run_sweep(input string tag, input bit s, input logic [7:0] ett,
                             input logic [7:0] g, input bit slow);
        int nv, st, ecnt, fvec, last, tdone;
        bit fvld;
        @(negedge clk);
        sel = s;
        nv  = s ? 8 : 4;
        st  = s ? 3 : 1;
        if (s) begin
            gtt_b = g; exp_b = ett;
        end else begin
            gtt_a = g[3:0]; exp_a = ett[3:0]; slow_a = slow;
        end
        repeat (3) @(negedge clk);
        model(ett, g, nv, slow && !s, ecnt, fvec, fvld, last);
        tdone = (last + 1) * (st + 1);
        if (s) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        for (int c = 0; c < tdone; c++) begin
            check($sformatf("%s.busy@%0d", tag, c), 32'(busy_m), 32'd1);
            check($sformatf("%s.done@%0d", tag, c), 32'(done_m), 32'd0);
            check($sformatf("%s.din@%0d", tag, c), 32'(din_m), 32'(c / (st + 1)));
            @(negedge clk);
        end
        check({tag, ".done"}, 32'(done_m), 32'd1);
        check({tag, ".busy_end"}, 32'(busy_m), 32'd0);
        check({tag, ".pass"}, 32'(pass_m), 32'(ecnt == 0));
        check({tag, ".err"}, 32'(err_m), 32'(ecnt));
        check({tag, ".fvld"}, 32'(fvld_m), 32'(fvld));
        if (fvld) check({tag, ".fvec"}, 32'(fv_m), 32'(fvec));
        @(negedge clk);
        check({tag, ".done_1cyc"}, 32'(done_m), 32'd0);
        check({tag, ".pass_hold"}, 32'(pass_m), 32'(ecnt == 0));
        check({tag, ".err_hold"}, 32'(err_m), 32'(ecnt));
    endtask

    initial begin
        int dones;
        logic [7:0] g, e;
        bit s, sl;

        #3;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_sweep("and2", 1'b0, 8'h08, 8'h08, 1'b0);
        run_sweep("or2", 1'b0, 8'h08, 8'h0E, 1'b0);
        run_sweep("inv_all", 1'b0, 8'h08, 8'h07, 1'b0);
        run_sweep("slow_s1", 1'b0, 8'h08, 8'h08, 1'b1);
        run_sweep("and3_s3", 1'b1, 8'h80, 8'h80, 1'b0);

        // Start held high: one idle edge between back-to-back sweeps, then it drops.
        @(negedge clk);
        sel = 1'b0; gtt_a = 4'b1000; exp_a = 4'b1000; slow_a = 1'b0;
        repeat (3) @(negedge clk);
        start_a = 1'b1;
        dones = 0;
        @(negedge clk);
        for (int c = 0; c < 26; c++) begin
            check($sformatf("held.done@%0d", c), 32'(done_a), 32'((c == 8) || (c == 17)));
            if (c >= 18) check($sformatf("held.busy@%0d", c), 32'(busy_a), 32'd0);
            if (done_a) dones++;
            if (c == 17) start_a = 1'b0;
            @(negedge clk);
        end
        check("held.count", 32'(dones), 32'd2);

        // Reset in the middle of a sweep.
        gtt_a = 4'b1000; exp_a = 4'b1000;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done_a) dones++;
        end
        check("midrst.no_done", 32'(dones), 32'd0);
        run_sweep("post_rst", 1'b0, 8'h08, 8'h08, 1'b0);

        for (int i = 0; i < 12; i++) begin
            s  = 1'($urandom_range(0, 1));
            sl = 1'($urandom_range(0, 1));
            g  = 8'($urandom);
            e  = ($urandom_range(0, 2) == 0) ? g : 8'($urandom);
            run_sweep($sformatf("rnd%0d", i), s, e, g, sl);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
